// File: rtl/pack_drain_q.sv
// Multi-write, single-read queue: accepts 0..N contiguous lanes per cycle and drains
// them one per cycle in arrival order, lane 0 first within a beat.
module pack_drain_q #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N*W-1:0]             in_w,
    input  logic [N-1:0]               in_vld_w,
    output logic                       in_rdy_r,
    output logic [W-1:0]               out_w,
    output logic                       out_vld_r,
    input  logic                       out_rdy,
    output logic                       ovf_r,
    output logic                       err_r,
    output logic [$clog2(DEPTH):0]     cnt_r
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned KW = $clog2(N) + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic [N-1:0]  vld_p1;
    logic          unary;
    logic [KW-1:0] k;
    logic          wr_acc;
    logic          ovf_hit;
    logic          pop;
    logic [CW-1:0] k_acc;
    logic [CW-1:0] cnt_next;
    logic [CW-1:0] free_next;

    // Unary (2^k - 1) masks have no bit set above a clear bit: v & (v + 1) == 0.
    always_comb begin
        vld_p1 = in_vld_w + N'(1);
        unary  = ((in_vld_w & vld_p1) == '0);
        k      = '0;
        for (int i = 0; i < N; i++) begin
            k = k + KW'(in_vld_w[i]);
        end
    end

    always_comb begin
        wr_acc    = unary && (k != '0) && in_rdy_r;
        ovf_hit   = unary && (k != '0) && !in_rdy_r;
        pop       = out_vld_r && out_rdy;
        k_acc     = wr_acc ? CW'(k) : '0;
        cnt_next  = cnt_r + k_acc - CW'(pop);
        free_next = CW'(DEPTH) - cnt_next;
    end

    assign out_w = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_r     <= '0;
            out_vld_r <= 1'b0;
            in_rdy_r  <= 1'b1;
            ovf_r     <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(k);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt_r     <= cnt_next;
            out_vld_r <= (cnt_next != '0);
            in_rdy_r  <= (free_next >= CW'(N));
            if (!unary) begin
                err_r <= 1'b1;
            end else if (ovf_hit) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            for (int i = 0; i < N; i++) begin
                if (in_vld_w[i]) begin
                    mem[wr_ptr + PW'(i)] <= in_w[i*W +: W];
                end
            end
        end
    end

endmodule
